// File: rtl/top_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_pkg
// Description : Shared widths for the registered adder/multiplier unit.
// Revision    : 1.0 - initial release
// ============================================================================
package top_pkg;

    localparam int unsigned N_DEFAULT = 4;
    localparam int unsigned SUM_W     = N_DEFAULT + 1;
    localparam int unsigned PROD_W    = 2 * N_DEFAULT;

    function automatic int unsigned sum_width(input int unsigned n);
        return n + 1;
    endfunction

    function automatic int unsigned prod_width(input int unsigned n);
        return 2 * n;
    endfunction

endpackage : top_pkg
`default_nettype wire

// File: rtl/rca_adder.sv
`default_nettype none
// ============================================================================
// Module      : rca_adder
// Description : W-bit ripple-carry adder built from full-adder bit cells.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_adder #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign co = w_c[W];

endmodule : rca_adder
`default_nettype wire

// File: rtl/top.sv
`default_nettype none
// ============================================================================
// Module      : top
// Description : Registered N-bit unsigned adder (with carry) and 2N-bit
//               shift-and-add multiplier sharing one operand pair.
// Revision    : 1.0 - initial release
// ============================================================================
module top
    import top_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic           cin,
    output logic [N-1:0]   sum,
    output logic           cout,
    output logic [2*N-1:0] prod
);

    logic [N-1:0]          w_sum;
    logic                  w_cout;
    logic [N-1:0][N-1:0]   w_pp;
    logic [N-1:0][N-1:0]   w_row_s;
    logic [N-1:0]          w_row_c;
    logic [2*N-1:0]        w_prod;

    logic [N-1:0]          r_sum;
    logic                  r_cout;
    logic [2*N-1:0]        r_prod;

    rca_adder #(.W(N)) u_sum_adder (
        .a  (x),
        .b  (y),
        .ci (cin),
        .s  (w_sum),
        .co (w_cout)
    );

    for (genvar i = 0; i < N; i++) begin : g_pp
        assign w_pp[i] = x & {N{y[i]}};
    end

    // Row 0 is the bare first partial product; each later row adds the next
    // partial product to the previous row shifted right by one (carry on top).
    assign w_row_s[0] = w_pp[0];
    assign w_row_c[0] = 1'b0;

    for (genvar i = 1; i < N; i++) begin : g_rows
        rca_adder #(.W(N)) u_row_adder (
            .a  (w_pp[i]),
            .b  ({w_row_c[i-1], w_row_s[i-1][N-1:1]}),
            .ci (1'b0),
            .s  (w_row_s[i]),
            .co (w_row_c[i])
        );
    end

    for (genvar i = 0; i < N; i++) begin : g_prod_lo
        assign w_prod[i] = w_row_s[i][0];
    end

    assign w_prod[2*N-1:N] = {w_row_c[N-1], w_row_s[N-1][N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_prod <= '0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_prod <= w_prod;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign prod = r_prod;

endmodule : top
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_top
// Description : Directed and exhaustive self-checking bench for top (N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           cin;
    logic [N-1:0]   sum;
    logic           cout;
    logic [2*N-1:0] prod;

    int n_checks = 0;
    int n_errors = 0;

    top #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .y    (y),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .prod (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        rst = r;
        x   = a;
        y   = b;
        cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] cs, input logic [7:0] p);
        check({tag, "_cs"}, {11'd0, cout, sum}, {11'd0, cs});
        check({tag, "_prod"}, {8'd0, prod}, {8'd0, p});
    endtask

    initial begin
        rst = 1'b1;
        x   = '0;
        y   = '0;
        cin = 1'b0;
        #2;

        step(1'b1, 4'hF, 4'hF, 1'b1);
        expect_out("reset1", 5'h00, 8'h00);
        step(1'b1, 4'hF, 4'hF, 1'b1);
        expect_out("reset2", 5'h00, 8'h00);
        step(1'b0, 4'hF, 4'hF, 1'b1);
        expect_out("post_reset", 5'h1F, 8'hE1);

        step(1'b0, 4'h3, 4'h5, 1'b0);
        expect_out("basic_3_5", 5'h08, 8'h0F);
        step(1'b0, 4'h8, 4'h8, 1'b0);
        expect_out("basic_8_8", 5'h10, 8'h40);

        step(1'b0, 4'hF, 4'hF, 1'b0);
        expect_out("max_cin0", 5'h1E, 8'hE1);
        step(1'b0, 4'hF, 4'hF, 1'b1);
        expect_out("max_cin1", 5'h1F, 8'hE1);

        step(1'b0, 4'h0, 4'h9, 1'b0);
        expect_out("zero_x", 5'h09, 8'h00);
        step(1'b0, 4'h7, 4'h0, 1'b1);
        expect_out("zero_y", 5'h08, 8'h00);

        step(1'b0, 4'hA, 4'h6, 1'b0);
        expect_out("carry_edge", 5'h10, 8'h3C);
        step(1'b0, 4'h9, 4'h6, 1'b0);
        expect_out("no_carry_edge", 5'h0F, 8'h36);

        // Back-to-back stream: a new vector each edge, result checked one edge later.
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    logic [4:0] exp_cs;
                    logic [7:0] exp_p;
                    exp_cs = 5'(a + b + c);
                    exp_p  = 8'(a * b);
                    step(1'b0, 4'(a), 4'(b), 1'(c));
                    expect_out("exhaustive", exp_cs, exp_p);
                end
            end
        end

        step(1'b0, 4'h2, 4'h3, 1'b0);
        expect_out("stream_a", 5'h05, 8'h06);
        step(1'b1, 4'hC, 4'hD, 1'b1);
        expect_out("mid_reset", 5'h00, 8'h00);
        step(1'b0, 4'h4, 4'h6, 1'b1);
        expect_out("after_mid_reset", 5'h0B, 8'h18);
        step(1'b0, 4'hE, 4'h3, 1'b1);
        expect_out("stream_b", 5'h12, 8'h2A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_top
`default_nettype wire
